// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core.
// Carries the decoded control bundle and operand/data fields from decode into
// execute. It also detects load-use hazards: when the instruction in EX is a
// load whose destination is a source of the instruction in ID, this stage holds
// ID and puts a single bubble into EX.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [2:0]      id_funct3,
    input  logic            dec_reg_write,
    input  logic [1:0]      dec_mem_to_reg,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_is_branch,
    input  logic            dec_is_jal,
    input  logic            dec_is_jalr,
    input  logic            dec_opa_sel,
    input  logic            dec_opb_sel,
    input  logic [3:0]      dec_alu_op,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_use_rs1,
    output logic            ex_use_rs2,
    output logic [2:0]      ex_funct3,
    output logic            ex_reg_write,
    output logic [1:0]      ex_mem_to_reg,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_is_branch,
    output logic            ex_is_jal,
    output logic            ex_is_jalr,
    output logic            ex_opa_sel,
    output logic            ex_opb_sel,
    output logic [3:0]      ex_alu_op,
    output logic            load_use_stall
);

    // Control fields are zeroed on bubbles/flushes; data fields are simply carried.
    localparam int CTRL_W = 14;
    localparam int DATA_W = 4 * XLEN + 3 * REGW + 5;

    logic [CTRL_W-1:0] dec_ctrl_s;
    logic [CTRL_W-1:0] ex_ctrl_r;
    logic [DATA_W-1:0] id_data_s;
    logic [DATA_W-1:0] ex_data_r;
    logic              ex_valid_r;
    logic              rs1_match_s;
    logic              rs2_match_s;
    logic              hazard_s;

    assign dec_ctrl_s = {dec_reg_write, dec_mem_to_reg, dec_is_load, dec_is_store,
                         dec_is_branch, dec_is_jal, dec_is_jalr, dec_opa_sel,
                         dec_opb_sel, dec_alu_op};

    assign id_data_s = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
                        id_rd, id_use_rs1, id_use_rs2, id_funct3};

    assign {ex_reg_write, ex_mem_to_reg, ex_is_load, ex_is_store, ex_is_branch,
            ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel, ex_alu_op} = ex_ctrl_r;

    assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_use_rs1, ex_use_rs2, ex_funct3} = ex_data_r;

    assign ex_valid = ex_valid_r;

    // Load-use hazard: a live load in EX writing a non-x0 register that ID reads.
    always_comb begin
        rs1_match_s    = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_match_s    = id_use_rs2 & (id_rs2 == ex_rd);
        hazard_s       = ex_valid_r & ex_is_load & (ex_rd != {REGW{1'b0}}) & id_valid &
                         (rs1_match_s | rs2_match_s);
        load_use_stall = hazard_s & ~flush;
        id_ready       = ~ex_stall & ~load_use_stall;
    end

    // EX slot update with priority reset > flush > stall > hazard bubble > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= {CTRL_W{1'b0}};
            ex_data_r  <= {DATA_W{1'b0}};
        end else if (flush) begin
            // Kill the EX slot even if EX is stalled; data fields are left as they were.
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= {CTRL_W{1'b0}};
            ex_data_r  <= ex_data_r;
        end else if (ex_stall) begin
            // Hold everything; no bubble is inserted while EX is frozen.
            ex_valid_r <= ex_valid_r;
            ex_ctrl_r  <= ex_ctrl_r;
            ex_data_r  <= ex_data_r;
        end else if (hazard_s) begin
            // One bubble; ID is held and re-presents the same instruction next cycle.
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= {CTRL_W{1'b0}};
            ex_data_r  <= ex_data_r;
        end else begin
            ex_valid_r <= id_valid;
            ex_ctrl_r  <= id_valid ? dec_ctrl_s : {CTRL_W{1'b0}};
            ex_data_r  <= id_data_s;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [2:0]  id_funct3;
    logic        dec_reg_write;
    logic [1:0]  dec_mem_to_reg;
    logic        dec_is_load, dec_is_store, dec_is_branch, dec_is_jal, dec_is_jalr;
    logic        dec_opa_sel, dec_opb_sel;
    logic [3:0]  dec_alu_op;
    logic        ex_stall, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_use_rs1, ex_use_rs2;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic [1:0]  ex_mem_to_reg;
    logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic        ex_opa_sel, ex_opb_sel;
    logic [3:0]  ex_alu_op;
    logic        load_use_stall;

    int tests;
    int failed;

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
        .dec_reg_write(dec_reg_write), .dec_mem_to_reg(dec_mem_to_reg),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .dec_is_jal(dec_is_jal),
        .dec_is_jalr(dec_is_jalr), .dec_opa_sel(dec_opa_sel),
        .dec_opb_sel(dec_opb_sel), .dec_alu_op(dec_alu_op),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .ex_funct3(ex_funct3),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_opa_sel(ex_opa_sel),
        .ex_opb_sel(ex_opb_sel), .ex_alu_op(ex_alu_op),
        .load_use_stall(load_use_stall)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_clear();
        id_valid = 1'b0; id_pc = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0;
        id_imm = 32'h0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_funct3 = 3'd0;
        dec_reg_write = 1'b0; dec_mem_to_reg = 2'd0; dec_is_load = 1'b0;
        dec_is_store = 1'b0; dec_is_branch = 1'b0; dec_is_jal = 1'b0;
        dec_is_jalr = 1'b0; dec_opa_sel = 1'b0; dec_opb_sel = 1'b0; dec_alu_op = 4'd0;
    endtask

    task automatic drive_add(input logic [31:0] pc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2);
        drive_clear();
        id_valid = 1'b1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        dec_reg_write = 1'b1;
    endtask

    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [31:0] imm);
        drive_clear();
        id_valid = 1'b1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs1_data = d1;
        id_imm = imm; id_use_rs1 = 1'b1; id_funct3 = 3'b010;
        dec_reg_write = 1'b1; dec_mem_to_reg = 2'b01; dec_is_load = 1'b1;
        dec_opb_sel = 1'b1;
    endtask

    task automatic drive_sw(input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] imm);
        drive_clear();
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1;
        id_rs2_data = d2; id_imm = imm; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_funct3 = 3'b010; dec_is_store = 1'b1; dec_opb_sel = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'b1; id_pc = $urandom; id_rs1_data = $urandom;
            id_rs2_data = $urandom; id_imm = $urandom; id_rs1 = 5'($urandom);
            id_rs2 = 5'($urandom); id_rd = 5'($urandom); id_use_rs1 = 1'b1;
            id_use_rs2 = 1'b1; id_funct3 = 3'($urandom); dec_reg_write = 1'b1;
            dec_mem_to_reg = 2'b01; dec_is_load = 1'b1; dec_is_store = 1'b1;
            dec_is_branch = 1'b1; dec_is_jal = 1'b1; dec_is_jalr = 1'b1;
            dec_opa_sel = 1'b1; dec_opb_sel = 1'b1; dec_alu_op = 4'($urandom);
            tick();
        end
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        tests++; if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== 128'h0) begin failed++; $display("FAIL reset_data got pc=%h rs1d=%h rs2d=%h imm=%h exp=0", ex_pc, ex_rs1_data, ex_rs2_data, ex_imm); end
        tests++; if ({ex_rs1, ex_rs2, ex_rd, ex_use_rs1, ex_use_rs2, ex_funct3} !== 20'h0) begin failed++; $display("FAIL reset_idx got rs1=%0d rs2=%0d rd=%0d exp=0", ex_rs1, ex_rs2, ex_rd); end
        tests++; if ({ex_reg_write, ex_mem_to_reg, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel, ex_alu_op} !== 14'h0) begin failed++; $display("FAIL reset_ctrl got nonzero control exp=0"); end
        tests++; if (id_ready !== 1'b1) begin failed++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
        rst = 1'b0;
        drive_clear();
    endtask

    task automatic test_add();
        drive_add(32'h100, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        #1;
        tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failed++; $display("FAIL add_ready got stall=%b ready=%b exp 0/1", load_use_stall, id_ready); end
        tick();
        tests++; if (ex_valid !== 1'b1) begin failed++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
        tests++; if (ex_rs1_data !== 32'd5 || ex_rs2_data !== 32'd7) begin failed++; $display("FAIL add_data got %0d,%0d exp 5,7", ex_rs1_data, ex_rs2_data); end
        tests++; if (ex_reg_write !== 1'b1 || ex_alu_op !== 4'b0000) begin failed++; $display("FAIL add_ctrl got rw=%b alu=%b exp 1/0000", ex_reg_write, ex_alu_op); end
        tests++; if (ex_rd !== 5'd3 || ex_pc !== 32'h100) begin failed++; $display("FAIL add_rd_pc got rd=%0d pc=%h exp 3/100", ex_rd, ex_pc); end
    endtask

    task automatic test_load_use();
        drive_lw(32'h104, 5'd5, 5'd1, 32'h1000, 32'd8);
        tick();
        tests++; if (ex_is_load !== 1'b1 || ex_mem_to_reg !== 2'b01 || ex_imm !== 32'd8 || ex_funct3 !== 3'b010) begin failed++; $display("FAIL lw_fields got ld=%b m2r=%b imm=%0d f3=%b exp 1/01/8/010", ex_is_load, ex_mem_to_reg, ex_imm, ex_funct3); end
        drive_add(32'h108, 5'd6, 5'd5, 5'd1, 32'hAA, 32'hBB);
        #1;
        tests++; if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin failed++; $display("FAIL lu_detect got stall=%b ready=%b exp 1/0", load_use_stall, id_ready); end
        tick();
        tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin failed++; $display("FAIL lu_bubble got v=%b rw=%b ld=%b exp 0/0/0", ex_valid, ex_reg_write, ex_is_load); end
        tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failed++; $display("FAIL lu_release got stall=%b ready=%b exp 0/1", load_use_stall, id_ready); end
        tick();
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h108 || ex_rs1_data !== 32'hAA) begin failed++; $display("FAIL lu_arrive got v=%b rd=%0d pc=%h d=%h exp 1/6/108/aa", ex_valid, ex_rd, ex_pc, ex_rs1_data); end
    endtask

    task automatic test_no_hazard();
        drive_lw(32'h10C, 5'd0, 5'd1, 32'h0, 32'd0);
        tick();
        drive_add(32'h110, 5'd7, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failed++; $display("FAIL x0_nohaz got stall=%b ready=%b exp 0/1", load_use_stall, id_ready); end
        drive_lw(32'h114, 5'd5, 5'd1, 32'h0, 32'd0);
        tick();
        drive_add(32'h118, 5'd8, 5'd1, 5'd5, 32'd1, 32'd2);
        id_use_rs2 = 1'b0;
        #1;
        tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failed++; $display("FAIL unused_rs2 got stall=%b ready=%b exp 0/1", load_use_stall, id_ready); end
        id_use_rs2 = 1'b1;
        #1;
        tests++; if (load_use_stall !== 1'b1) begin failed++; $display("FAIL rs2_haz got stall=%b exp 1", load_use_stall); end
        id_valid = 1'b0;
        #1;
        tests++; if (load_use_stall !== 1'b0) begin failed++; $display("FAIL invalid_id got stall=%b exp 0", load_use_stall); end
        drive_clear();
        tick();
    endtask

    task automatic test_stall();
        drive_sw(32'h200, 5'd2, 5'd3, 32'h2000, 32'hDEAD, 32'd4);
        tick();
        tests++; if (ex_is_store !== 1'b1 || ex_valid !== 1'b1) begin failed++; $display("FAIL sw_enter got st=%b v=%b exp 1/1", ex_is_store, ex_valid); end
        drive_add(32'h204, 5'd9, 5'd4, 5'd4, 32'h11, 32'h22);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (id_ready !== 1'b0) begin failed++; $display("FAIL stall_ready cyc=%0d got=%b exp 0", i, id_ready); end
            tick();
            tests++; if (ex_pc !== 32'h200 || ex_is_store !== 1'b1 || ex_rs2_data !== 32'hDEAD || ex_valid !== 1'b1 || ex_reg_write !== 1'b0) begin failed++; $display("FAIL stall_hold cyc=%0d got pc=%h st=%b d=%h v=%b exp 200/1/dead/1", i, ex_pc, ex_is_store, ex_rs2_data, ex_valid); end
        end
        ex_stall = 1'b0;
        #1;
        tests++; if (id_ready !== 1'b1) begin failed++; $display("FAIL stall_release got=%b exp 1", id_ready); end
        tick();
        tests++; if (ex_pc !== 32'h204 || ex_is_store !== 1'b0 || ex_reg_write !== 1'b1 || ex_rd !== 5'd9) begin failed++; $display("FAIL stall_advance got pc=%h st=%b rw=%b rd=%0d exp 204/0/1/9", ex_pc, ex_is_store, ex_reg_write, ex_rd); end
    endtask

    task automatic test_flush();
        drive_lw(32'h300, 5'd5, 5'd1, 32'h0, 32'd12);
        tick();
        drive_add(32'h304, 5'd6, 5'd5, 5'd1, 32'd0, 32'd0);
        ex_stall = 1'b1;
        #1;
        tests++; if (load_use_stall !== 1'b1) begin failed++; $display("FAIL fl_pre_haz got=%b exp 1", load_use_stall); end
        tick();
        tests++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1) begin failed++; $display("FAIL stall_no_bubble got v=%b ld=%b exp 1/1", ex_valid, ex_is_load); end
        flush = 1'b1;
        #1;
        tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b0) begin failed++; $display("FAIL fl_comb got stall=%b ready=%b exp 0/0", load_use_stall, id_ready); end
        tick();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL fl_valid got=%b exp 0", ex_valid); end
        tests++; if ({ex_reg_write, ex_mem_to_reg, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel, ex_alu_op} !== 14'h0) begin failed++; $display("FAIL fl_ctrl got rw=%b m2r=%b ld=%b opb=%b exp 0", ex_reg_write, ex_mem_to_reg, ex_is_load, ex_opb_sel); end
        flush = 1'b0; ex_stall = 1'b0;
        drive_clear();
        dec_reg_write = 1'b1; dec_is_jal = 1'b1;
        tick();
        tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_jal !== 1'b0) begin failed++; $display("FAIL idle_ctrl got v=%b rw=%b jal=%b exp 0/0/0", ex_valid, ex_reg_write, ex_is_jal); end
    endtask

    task automatic test_back_to_back();
        drive_lw(32'h400, 5'd5, 5'd1, 32'h0, 32'd0);
        tick();
        drive_lw(32'h404, 5'd6, 5'd5, 32'h0, 32'd0);
        #1;
        tests++; if (load_use_stall !== 1'b1) begin failed++; $display("FAIL b2b_haz1 got=%b exp 1", load_use_stall); end
        tick();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL b2b_bubble1 got=%b exp 0", ex_valid); end
        tick();
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_is_load !== 1'b1) begin failed++; $display("FAIL b2b_lw2 got v=%b rd=%0d ld=%b exp 1/6/1", ex_valid, ex_rd, ex_is_load); end
        drive_add(32'h408, 5'd7, 5'd6, 5'd2, 32'd0, 32'd0);
        #1;
        tests++; if (load_use_stall !== 1'b1) begin failed++; $display("FAIL b2b_haz2 got=%b exp 1", load_use_stall); end
        tick();
        tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL b2b_bubble2 got=%b exp 0", ex_valid); end
        tick();
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h408) begin failed++; $display("FAIL b2b_add got v=%b rd=%0d pc=%h exp 1/7/408", ex_valid, ex_rd, ex_pc); end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        drive_clear();
        test_reset();
        test_add();
        test_load_use();
        test_no_hazard();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
